ps2_rx: RTL and testbench
=========================

Name: ps2_rx

Overview:
- PS/2 keyboard receive front-end, directly upstream of io_bridge's keyboard register.
- Synchronizes and deglitches the keyboard clock and data lines, then deframes 11-bit device-to-host frames and checks odd parity.
- Valid scan-code bytes go into a small show-ahead FIFO that io_bridge pops.
- Pulses an interrupt request per received byte; error flags are sticky.

Parameters:
FIFO_DEPTH, 16, scan-code FIFO entries; power of 2, at least 2
FILTER_LEN, 8, consecutive equal clk samples required before filtered ps2_clk changes
TIMEOUT_CYC, 50000, max clk cycles between PS/2 clock falling edges inside a frame (1 ms at 50 MHz)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous, active-low reset
ps2_clk  in  1  keyboard clock line, input sample only (io_bridge owns the inout pad)
ps2_data  in  1  keyboard data line, input sample only
rd  in  1  pop strobe from io_bridge
rd_data  out  8  FIFO head byte, show-ahead
valid  out  1  FIFO non-empty
level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
irq  out  1  one-cycle pulse per byte pushed
parity_err  out  1  sticky: parity or stop-bit failure
overflow  out  1  sticky: byte dropped because FIFO was full
clr_err  in  1  clears parity_err and overflow

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM goes to IDLE, bit count 0, watchdog 0, FIFO empty.
  - Outputs: rd_data=0, valid=0, level=0, irq=0, parity_err=0, overflow=0.
  - Synchronizers and the filtered clock initialise to 1.
  - Reset mid-frame discards the partial frame.
- Input conditioning:
  - 2-FF synchronizer on each line.
  - Filtered clock toggles only after FILTER_LEN consecutive equal synchronized samples.
  - "fall" is a one-cycle strobe when the filtered clock goes 1 to 0.
  - Data is sampled from the synchronized ps2_data in the fall cycle.
- FSM, with transitions on fall only:
  - IDLE: data=0 goes to DATA and clears the shift register and count. data=1 (no start bit) stays in IDLE with no flag.
  - DATA: shift LSB-first; after the 8th bit go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: the frame is good if stop=1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity). A good frame is pushed; otherwise set parity_err and push nothing. Always return to IDLE.
- Watchdog:
  - In any state other than IDLE, count clk cycles and clear the count on fall.
  - When the count reaches TIMEOUT_CYC, force IDLE, discard the frame, set no flag.
- FIFO push/pop timing:
  - A push occurs in the STOP fall cycle.
  - In the next cycle: valid=1, level updated, rd_data shows the head (if the FIFO was empty), irq=1 for exactly one cycle.
- Pop:
  - rd with valid=1 advances the head; the new head appears the next cycle.
  - rd with valid=0 is ignored.
- FIFO boundary cases:
  - Push while full and no rd: byte dropped, overflow set, irq not pulsed.
  - Push and rd in the same cycle while full: both succeed, level unchanged, irq pulses.
  - Push and rd in the same cycle while empty: push succeeds, rd ignored.
  - Pointers wrap modulo FIFO_DEPTH; full and empty are distinguished by the extra level bit.
- Flags:
  - clr_err in the same cycle as a new error: set wins.
  - Flags never clear except by clr_err or reset.

Decomposition:
- Package ps2_pkg holds the FSM state enum (IDLE, DATA, PARITY, STOP), DATA_BITS=8, and the frame-length constant 11.
- One sub-module, sync_fifo:
  - Parameterised width and depth, show-ahead.
  - Provides push, pop, full, empty and level, with the drop-on-full rule above.
- ps2_rx holds the conditioning logic, FSM, watchdog and flags.

Test Plan:
1. Frame for 0x1C (start 0, data LSB-first, parity 0, stop 1) at a 20 us PS/2 period → valid=1, rd_data=0x1C, level=1, irq high exactly one cycle; after rd, valid=0, level=0.
2. 0x1C frame with parity 1 → nothing pushed, level=0, parity_err=1. Then pulse clr_err → parity_err=0. Then send 0xF0 with parity 1 → rd_data=0xF0.
3. 3-cycle low glitch on ps2_clk (less than FILTER_LEN) while idle, then a full 0x5A frame (parity 1) → exactly one byte 0x5A, no errors.
4. Start bit plus 4 data bits, then the line idles beyond TIMEOUT_CYC → FSM back in IDLE, nothing pushed. A following 0x29 frame (parity 0) is received correctly.
5. 17 frames 0x00..0x10 with no rd → level=16, overflow=1, pops return 0x00..0x0F in order. Refill to full, then assert rd in the push cycle → level stays 16, irq pulses, overflow unchanged.
6. Assert rst_n=0 for one cycle during data bit 5 → all outputs 0. The next complete 0x1C frame is received cleanly.

Source files
------------

// File: rtl/ps2_pkg.sv
// PS/2 receive shared types: deframer states, frame geometry, frame check helper.
// No logic or latency of its own.
// No flow control; pure definitions.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;

  // Good frame: stop bit high and odd parity over data plus parity bit.
  function automatic logic frame_ok(input logic [DATA_BITS-1:0] d,
                                    input logic par,
                                    input logic stop);
    return stop & (^{d, par});
  endfunction

endpackage

// File: rtl/ps2_rx_if.sv
// Host-side bundle between ps2_rx and io_bridge: FIFO pop port, status, irq.
// Combinational wires only.
// io_bridge pops via rd; ps2_rx ignores rd while valid is low.
interface ps2_rx_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             rd;
  logic             clr_err;
  logic [7:0]       rd_data;
  logic             valid;
  logic [LVL_W-1:0] level;
  logic             irq;
  logic             parity_err;
  logic             overflow;

  modport master (
    output rd, clr_err,
    input  rd_data, valid, level, irq, parity_err, overflow
  );

  modport slave (
    input  rd, clr_err,
    output rd_data, valid, level, irq, parity_err, overflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count.
// Write visible at head the cycle after push; pop advances head next cycle.
// Push while full is dropped unless a pop is accepted in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     push_ok
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    cnt;
  logic             pop_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == LW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A full FIFO can still take a byte when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign level   = cnt;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: sync/deglitch, 11-bit deframe, odd parity, scan-code FIFO.
// Byte visible (valid, irq) one cycle after the stop-bit falling edge.
// No backpressure to the keyboard: bytes arriving with a full FIFO are dropped and flagged.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_rx_if.slave host
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam int BW = $clog2(DATA_BITS);

  logic [1:0]           clk_sync;
  logic [1:0]           dat_sync;
  logic                 clk_s;
  logic                 dat_s;
  logic                 filt_clk;
  logic [FW-1:0]        flt_cnt;
  logic                 flt_done;
  logic                 fall;

  ps2_state_e           state_q;
  ps2_state_e           state_d;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0]        bit_cnt;
  logic                 par_q;
  logic [WW-1:0]        wdog;
  logic                 timeout;

  logic                 clr_frame;
  logic                 shift_en;
  logic                 cap_par;
  logic                 push;
  logic                 perr_set;

  logic                 push_ok;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 irq_q;
  logic                 parity_err_q;
  logic                 overflow_q;

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  // Filtered clock follows the synced line only after FILTER_LEN differing samples in a row.
  assign flt_done = (clk_s != filt_clk) && (flt_cnt == FW'(FILTER_LEN - 1));
  assign fall     = flt_done && filt_clk;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_clk <= 1'b1;
      flt_cnt  <= '0;
    end else if (clk_s == filt_clk) begin
      flt_cnt <= '0;
    end else if (flt_done) begin
      filt_clk <= clk_s;
      flt_cnt  <= '0;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end

  assign timeout = (state_q != IDLE) && (wdog == WW'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    clr_frame = 1'b0;
    shift_en  = 1'b0;
    cap_par   = 1'b0;
    push      = 1'b0;
    perr_set  = 1'b0;
    if (fall) begin
      case (state_q)
        IDLE: begin
          if (!dat_s) begin
            state_d   = DATA;
            clr_frame = 1'b1;
          end
        end
        DATA: begin
          shift_en = 1'b1;
          if (bit_cnt == BW'(DATA_BITS - 1)) state_d = PARITY;
        end
        PARITY: begin
          cap_par = 1'b1;
          state_d = STOP;
        end
        STOP: begin
          if (frame_ok(shreg, par_q, dat_s)) push = 1'b1;
          else                               perr_set = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      par_q   <= 1'b0;
      wdog    <= '0;
    end else begin
      if (clr_frame) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end
      if (shift_en) begin
        shreg   <= {dat_s, shreg[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (cap_par) par_q <= dat_s;
      if (state_q == IDLE || fall) wdog <= '0;
      else                         wdog <= wdog + 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shreg),
    .pop       (host.rd),
    .pop_data  (host.rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (host.level),
    .push_ok   (push_ok)
  );

  // Set beats clear when an error and clr_err land in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_q        <= 1'b0;
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      irq_q <= push_ok;
      if (perr_set)          parity_err_q <= 1'b1;
      else if (host.clr_err) parity_err_q <= 1'b0;
      if (push && fifo_full && !host.rd) overflow_q <= 1'b1;
      else if (host.clr_err)             overflow_q <= 1'b0;
    end
  end

  assign host.valid      = ~fifo_empty;
  assign host.irq        = irq_q;
  assign host.parity_err = parity_err_q;
  assign host.overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: framing, parity, glitch filter, watchdog, FIFO limits, reset.
module tb_ps2_rx;
  import ps2_pkg::*;

  localparam int FIFO_DEPTH  = 16;
  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 600;
  localparam int HP          = 40;   // PS/2 half period in clk cycles

  logic clk;
  logic rst_n;
  logic ps2_clk;
  logic ps2_data;

  ps2_rx_if #(.FIFO_DEPTH(FIFO_DEPTH)) host ();

  ps2_rx #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .host     (host)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int irq_cnt = 0;
  int irq0;

  always @(negedge clk) if (host.irq) irq_cnt++;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sends the first nbits of {stop, par, d, start=0}; optional rd in the stop-bit push cycle.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int nbits, input bit rd_at_stop);
    logic [10:0] f;
    f = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (HP/2) @(negedge clk);
      ps2_clk = 1'b0;
      if (rd_at_stop && i == FRAME_BITS - 1) begin
        // 2 sync stages + FILTER_LEN filter samples put the fall cycle here.
        repeat (FILTER_LEN + 1) @(negedge clk);
        host.rd = 1'b1;
        @(negedge clk);
        host.rd = 1'b0;
        repeat (HP - FILTER_LEN - 2) @(negedge clk);
      end else begin
        repeat (HP) @(negedge clk);
      end
      ps2_clk = 1'b1;
      repeat (HP/2) @(negedge clk);
    end
    ps2_data = 1'b1;
    repeat (HP) @(negedge clk);
  endtask

  task automatic do_pop();
    host.rd = 1'b1;
    @(negedge clk);
    host.rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    host.clr_err = 1'b1;
    @(negedge clk);
    host.clr_err = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    host.rd = 1'b0;
    host.clr_err = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_valid", host.valid, 0);
    chk("rst_level", host.level, 0);
    chk("rst_rd_data", host.rd_data, 0);
    chk("rst_irq", host.irq, 0);
    chk("rst_parity_err", host.parity_err, 0);
    chk("rst_overflow", host.overflow, 0);

    // 1: good 0x1C
    irq0 = irq_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, FRAME_BITS, 1'b0);
    chk("t1_valid", host.valid, 1);
    chk("t1_rd_data", host.rd_data, 'h1C);
    chk("t1_level", host.level, 1);
    chk("t1_irq_cycles", irq_cnt - irq0, 1);
    do_pop();
    chk("t1_valid_after_pop", host.valid, 0);
    chk("t1_level_after_pop", host.level, 0);

    // 2: bad parity, clear, then good 0xF0
    irq0 = irq_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, FRAME_BITS, 1'b0);
    chk("t2_level_bad", host.level, 0);
    chk("t2_parity_err", host.parity_err, 1);
    chk("t2_no_irq", irq_cnt - irq0, 0);
    pulse_clr();
    chk("t2_parity_err_clr", host.parity_err, 0);
    send_frame(8'hF0, 1'b1, 1'b1, FRAME_BITS, 1'b0);
    chk("t2_rd_data", host.rd_data, 'hF0);
    chk("t2_level", host.level, 1);
    do_pop();

    // 3: short glitch on idle clock, then 0x5A
    irq0 = irq_cnt;
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HP) @(negedge clk);
    send_frame(8'h5A, 1'b1, 1'b1, FRAME_BITS, 1'b0);
    chk("t3_level", host.level, 1);
    chk("t3_rd_data", host.rd_data, 'h5A);
    chk("t3_parity_err", host.parity_err, 0);
    chk("t3_irq_count", irq_cnt - irq0, 1);
    do_pop();

    // 4: truncated frame recovered by the watchdog
    send_frame(8'h0F, 1'b1, 1'b1, 5, 1'b0);
    repeat (TIMEOUT_CYC + 200) @(negedge clk);
    chk("t4_state_idle", int'(dut.state_q), int'(IDLE));
    chk("t4_level_empty", host.level, 0);
    send_frame(8'h29, 1'b0, 1'b1, FRAME_BITS, 1'b0);
    chk("t4_level", host.level, 1);
    chk("t4_rd_data", host.rd_data, 'h29);
    chk("t4_parity_err", host.parity_err, 0);
    do_pop();

    // 5: overflow, ordering, then push+pop while full
    irq0 = irq_cnt;
    for (int i = 0; i <= 16; i++) begin
      logic [7:0] b;
      b = 8'(i);
      send_frame(b, ~^b, 1'b1, FRAME_BITS, 1'b0);
    end
    chk("t5_level_full", host.level, 16);
    chk("t5_overflow", host.overflow, 1);
    chk("t5_irq_count", irq_cnt - irq0, 16);
    for (int i = 0; i < 16; i++) begin
      chk("t5_pop_order", host.rd_data, i);
      do_pop();
    end
    chk("t5_drained", host.valid, 0);
    pulse_clr();
    chk("t5_overflow_clr", host.overflow, 0);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      b = 8'(8'h20 + i);
      send_frame(b, ~^b, 1'b1, FRAME_BITS, 1'b0);
    end
    chk("t5_refill_level", host.level, 16);
    irq0 = irq_cnt;
    send_frame(8'h30, 1'b1, 1'b1, FRAME_BITS, 1'b1);
    chk("t5_pushpop_level", host.level, 16);
    chk("t5_pushpop_irq", irq_cnt - irq0, 1);
    chk("t5_pushpop_overflow", host.overflow, 0);
    chk("t5_pushpop_head", host.rd_data, 'h21);

    // 6: reset mid-frame
    send_frame(8'h33, 1'b0, 1'b1, FRAME_BITS, 1'b0);
    chk("t6_parity_err_pre", host.parity_err, 1);
    send_frame(8'h1C, 1'b0, 1'b1, 6, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_valid", host.valid, 0);
    chk("t6_level", host.level, 0);
    chk("t6_rd_data", host.rd_data, 0);
    chk("t6_irq", host.irq, 0);
    chk("t6_parity_err", host.parity_err, 0);
    chk("t6_overflow", host.overflow, 0);
    send_frame(8'h1C, 1'b0, 1'b1, FRAME_BITS, 1'b0);
    chk("t6_rx_level", host.level, 1);
    chk("t6_rx_data", host.rd_data, 'h1C);
    chk("t6_rx_parity_err", host.parity_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
